// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX skid register: FSM state encoding and the
// EX/MEM/WB control bundle that gets zeroed on a bubble.
package id_ex_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  // ctrl_t fixes the ALU-function width; keep it equal to the ALUFN_W
  // parameter of id_ex_skid_reg.
  localparam int CTRL_ALUFN_W = 1;

  typedef struct packed {
    logic                    alusrc;
    logic [CTRL_ALUFN_W-1:0] alufn;
    logic                    memwrite;
    logic                    memread;
    logic                    memtoreg;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline stage with a one-entry skid buffer and
// synchronous flush; in_ready and out_valid decode straight from state flops.
//
// state | meaning
// EMPTY | nothing held, out_valid=0, in_ready=1
// FULL  | main holds the head entry, out_valid=1, in_ready=1
// SKID  | main holds head, skid holds the younger entry, in_ready=0
module pipe_skid_buf
  import id_ex_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk2,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (out_ready) begin
            state_d = EMPTY;
          end else if (in_valid) begin
            skid_d  = in_data;
            state_d = SKID;
          end
        end
        SKID: begin
          // in_valid is ignored here: in_ready is low for the whole state
          if (out_ready) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready skid buffering and flush.
// Define ID_EX_STATS_EN to add saturating stall_cnt / bubble_cnt outputs.
module id_ex_skid_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_W   = 8,
  parameter int ALUFN_W = 1
) (
  input  logic               clk2,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [REG_W-1:0]   in_m1,
  input  logic [REG_W-1:0]   in_m2,
  input  logic               in_alusrc,
  input  logic               in_memwrite,
  input  logic               in_memread,
  input  logic               in_memtoreg,
  input  logic [ALUFN_W-1:0] in_alufn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [REG_W-1:0]   out_m1,
  output logic [REG_W-1:0]   out_m2,
  output logic               out_alusrc,
  output logic               out_memwrite,
  output logic               out_memread,
  output logic               out_memtoreg,
  output logic [ALUFN_W-1:0] out_alufn
`ifdef ID_EX_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        bubble_cnt
`endif
);

  localparam int PAYLOAD_W = 3 * DATA_W + 2 * REG_W + CTRL_W;

  if (ALUFN_W != CTRL_ALUFN_W) begin : g_alufn_w_check
    $error("ALUFN_W must match id_ex_pkg::CTRL_ALUFN_W");
  end

  ctrl_t                in_ctrl, held_ctrl, out_ctrl;
  logic [PAYLOAD_W-1:0] in_payload, out_payload;

  always_comb begin
    in_ctrl          = BUBBLE_CTRL;
    in_ctrl.alusrc   = in_alusrc;
    in_ctrl.alufn    = in_alufn;
    in_ctrl.memwrite = in_memwrite;
    in_ctrl.memread  = in_memread;
    in_ctrl.memtoreg = in_memtoreg;
  end

  assign in_payload = {in_imm, in_a, in_b, in_m1, in_m2, in_ctrl};

  pipe_skid_buf #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk2     (clk2),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign {out_imm, out_a, out_b, out_m1, out_m2, held_ctrl} = out_payload;

  // Data fields keep their last value on a bubble; only controls are killed.
  assign out_ctrl     = out_valid ? held_ctrl : BUBBLE_CTRL;
  assign out_alusrc   = out_ctrl.alusrc;
  assign out_alufn    = out_ctrl.alufn;
  assign out_memwrite = out_ctrl.memwrite;
  assign out_memread  = out_ctrl.memread;
  assign out_memtoreg = out_ctrl.memtoreg;

`ifdef ID_EX_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (!out_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Parametrised ID/EX pipeline register for the core: carries the sign-extended immediate, operands A/B, register specifiers m1/m2 and the five EX/MEM/WB control bits from decode to execute.
- Adds a valid/ready handshake with a one-entry skid buffer, so an execute-side stall never propagates combinationally back to decode.
- Adds synchronous flush, which inserts a bubble.
- Single clock, 1-cycle latency, one transfer per cycle sustained.

Parameters:
- DATA_W, 8, width of imm, A, B
- REG_W, 8, width of m1, m2 specifiers
- ALUFN_W, 1, width of ALU function select

Ports:
- clk2  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  register can accept (registered output)
- in_imm  in  DATA_W  sign-extended immediate
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- in_m1  in  REG_W  specifier 1
- in_m2  in  REG_W  specifier 2
- in_alusrc, in_memwrite, in_memread, in_memtoreg  in  1 each  control bits
- in_alufn  in  ALUFN_W  ALU function
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute accepts this cycle
- out_imm, out_a, out_b  out  DATA_W
- out_m1, out_m2  out  REG_W
- out_alusrc, out_memwrite, out_memread, out_memtoreg  out  1 each
- out_alufn  out  ALUFN_W

Behaviour:
- Reset (async, rst_n=0): state EMPTY; out_valid=0; in_ready=1; all out_* data and control = 0; skid contents = 0.
- Transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
- States:
  - EMPTY (out_valid=0, in_ready=1): in_valid → load main, go FULL.
  - FULL (out_valid=1, in_ready=1):
    - in&out → main<=in, stay.
    - out only → EMPTY.
    - in only (out_ready=0) → skid<=in, go SKID.
    - neither → hold.
  - SKID (out_valid=1, in_ready=0): out_ready → main<=skid, FULL. Otherwise hold. in_valid is ignored.
- Latency: input accepted at edge N appears on out_* after edge N, stable through cycle N+1.
- Order is strictly preserved: the skid entry is always younger than main.
- Output stability: while out_valid=1 and out_ready=0, every out_* is bit-stable.
- Bubble rule: out_memwrite, out_memread, out_memtoreg, out_alusrc and out_alufn are 0 whenever out_valid=0. Data fields hold their last value (don't-care).
- Flush:
  - Highest priority over all handshakes, including a simultaneous in_valid, which is discarded.
  - Next cycle: EMPTY, out_valid=0, in_ready=1, controls 0, skid invalidated.
- Flush in SKID drops both entries.
- Reset asserted mid-transfer: immediate return to reset values; no partial update.
- in_ready and out_valid come directly from state flops; no comb path from out_ready to in_ready.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt [15:0]: increments each cycle out_valid&!out_ready.
  - bubble_cnt [15:0]: increments each cycle out_valid=0 after reset.
- Both counters saturate at 16'hFFFF, are cleared by rst_n only, and are unaffected by flush.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package id_ex_pkg holds:
  - state enum {EMPTY, FULL, SKID}
  - ctrl struct (alusrc, alufn, memwrite, memread, memtoreg)
  - CTRL_W constant
  - BUBBLE_CTRL constant (all zero)
- One sub-module, pipe_skid_buf:
  - Generic over PAYLOAD_W; implements the state machine and main/skid storage with flush.
  - id_ex_skid_reg packs and unpacks the fields and applies the bubble rule.

Test Plan:
- Stream: in_valid=1 for 4 cycles with A=8'h11..8'h14, out_ready=1 → out_a = 11,12,13,14 on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1.
- Backpressure: send A=8'h21 then 8'h22, out_ready=0 at 22's edge → state SKID, in_ready=0, out_a holds 21. out_ready=1 → 21 then 22 delivered, in_ready=1 again.
- Flush in SKID with in_valid=1 and A=8'h33 → next cycle out_valid=0, out_memwrite=0, in_ready=1; 33 never appears on the output.
- Bubble: in_memread=1, in_valid=1 for 1 cycle, then in_valid=0 → out_memread=1 for 1 cycle, then 0 while out_valid=0.
- Async reset: drop rst_n mid-cycle while in SKID → out_valid=0 and in_ready=1 immediately, all outputs 0; after release, first accepted input appears cleanly.
- With ID_EX_STATS_EN: hold out_ready=0 for 5 valid cycles → stall_cnt=5; force stall_cnt to 16'hFFFE, stall 3 cycles → reads 16'hFFFF.
